// File: rtl/wb_retire_queue_if.sv
// wb_retire_queue_if: MEM-to-WB handshake and instruction payload bus
interface wb_retire_queue_if #(parameter int DATA_W = 32);
  logic ms2ws_valid;
  logic ws_allowin;
  logic [DATA_W-1:0] ms_pc;
  logic [DATA_W+6:0] ms_rf_zip;
  logic [78:0] ms_csr_zip;
  logic [16:0] ms_ex_zip;
  modport master(output ms2ws_valid, ms_pc, ms_rf_zip, ms_csr_zip, ms_ex_zip, input ws_allowin);
  modport slave(input ms2ws_valid, ms_pc, ms_rf_zip, ms_csr_zip, ms_ex_zip, output ws_allowin);
endinterface

// File: rtl/wb_retire_queue.sv
// wb_retire_queue: in-order write-back retire queue with flush generation and ID bypass
module wb_retire_queue #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  wb_retire_queue_if.slave         ms,
  input  logic                     rf_grant,
  output logic                     rf_we,
  output logic [4:0]               rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic                     csr_re,
  output logic [13:0]              csr_num,
  input  logic [DATA_W-1:0]        csr_rvalue,
  output logic                     csr_we,
  output logic [DATA_W-1:0]        csr_wmask,
  output logic [DATA_W-1:0]        csr_wvalue,
  output logic                     wb_ex,
  output logic                     ertn_flush,
  output logic [DATA_W-1:0]        wb_pc,
  output logic [5:0]               wb_ecode,
  output logic [8:0]               wb_esubcode,
  input  logic [5*NUM_RD-1:0]      id_raddr,
  output logic [NUM_RD-1:0]        id_fwd_hit,
  output logic [DATA_W*NUM_RD-1:0] id_fwd_data,
  output logic [NUM_RD-1:0]        id_fwd_stall,
  output logic [DATA_W-1:0]        debug_wb_pc,
  output logic [3:0]               debug_wb_rf_we,
  output logic [4:0]               debug_wb_rf_wnum,
  output logic [DATA_W-1:0]        debug_wb_rf_wdata
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic              csr_re;
    logic              rf_we;
    logic [4:0]        waddr;
    logic [DATA_W-1:0] wdata;
    logic              csr_we;
    logic [13:0]       csr_num;
    logic [31:0]       wmask;
    logic [31:0]       wvalue;
    logic              ex;
    logic              ertn;
    logic [5:0]        ecode;
    logic [8:0]        esub;
  } ent_t;
  ent_t q [DEPTH];
  ent_t in_e, hd;
  logic [PW-1:0] head, tail, ix;
  logic [PW:0] idx;
  logic [CW-1:0] count;
  logic nonempty, retire, flush, allowin, enq;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign in_e = {ms.ms_pc, ms.ms_rf_zip, ms.ms_csr_zip, ms.ms_ex_zip};
  assign hd = q[head];
  assign nonempty = count != '0;
  // exceptions and ertn never touch the RF, so they leave without a grant
  assign retire = nonempty & (hd.ex | hd.ertn | rf_grant);
  assign flush = wb_ex | ertn_flush;
  assign allowin = ~reset & ((count < CW'(DEPTH)) | retire);
  assign ms.ws_allowin = allowin;
  assign enq = ms.ms2ws_valid & allowin & ~flush;
  assign rf_we = retire & hd.rf_we & ~hd.ex & ~hd.ertn;
  assign rf_waddr = retire ? hd.waddr : '0;
  assign rf_wdata = retire ? (hd.csr_re ? csr_rvalue : hd.wdata) : '0;
  assign csr_re = nonempty & hd.csr_re;
  assign csr_num = nonempty ? hd.csr_num : '0;
  assign wb_pc = nonempty ? hd.pc : '0;
  assign csr_we = retire & hd.csr_we & ~hd.ex;
  assign csr_wmask = retire ? DATA_W'(hd.wmask) : '0;
  assign csr_wvalue = retire ? DATA_W'(hd.wvalue) : '0;
  assign wb_ex = retire & hd.ex;
  assign ertn_flush = retire & hd.ertn & ~hd.ex;
  assign wb_ecode = wb_ex ? hd.ecode : '0;
  assign wb_esubcode = wb_ex ? hd.esub : '0;
  assign debug_wb_pc = wb_pc;
  assign debug_wb_rf_we = {4{rf_we}};
  assign debug_wb_rf_wnum = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        q[tail] <= in_e;
        tail <= nxt(tail);
      end
      if (retire) head <= nxt(head);
      count <= count + CW'(enq) - CW'(retire);
    end
  // walk oldest to youngest so the last match is the youngest writer
  always_comb begin
    id_fwd_hit = '0;
    id_fwd_data = '0;
    id_fwd_stall = '0;
    idx = '0;
    ix = '0;
    for (int p = 0; p < NUM_RD; p++)
      for (int i = 0; i < DEPTH; i++) begin
        idx = {1'b0, head} + (PW+1)'(i);
        idx = idx >= (PW+1)'(DEPTH) ? idx - (PW+1)'(DEPTH) : idx;
        ix = idx[PW-1:0];
        if (CW'(i) < count && q[ix].rf_we && !q[ix].ex && !q[ix].ertn &&
            id_raddr[p*5 +: 5] != 5'd0 && q[ix].waddr == id_raddr[p*5 +: 5]) begin
          id_fwd_hit[p] = 1'b1;
          id_fwd_stall[p] = q[ix].csr_re;
          id_fwd_data[p*DATA_W +: DATA_W] = q[ix].csr_re ? '0 : q[ix].wdata;
        end
      end
  end
endmodule

// File: tb/tb_wb_retire_queue.sv
// tb_wb_retire_queue: directed stimulus with a retire-event scoreboard and monitor
module tb_wb_retire_queue;
  logic clk = 0, reset = 1, rf_grant = 0;
  logic rf_we, csr_re, csr_we, wb_ex, ertn_flush;
  logic [4:0] rf_waddr, debug_wb_rf_wnum;
  logic [31:0] rf_wdata, csr_rvalue, csr_wmask, csr_wvalue, wb_pc, debug_wb_pc, debug_wb_rf_wdata;
  logic [13:0] csr_num;
  logic [5:0] wb_ecode;
  logic [8:0] wb_esubcode;
  logic [9:0] id_raddr;
  logic [1:0] id_fwd_hit, id_fwd_stall;
  logic [63:0] id_fwd_data;
  logic [3:0] debug_wb_rf_we;
  logic [55:0] sbq [$];
  logic [55:0] act, expv;
  int checks = 0, errors = 0;
  wb_retire_queue_if #(.DATA_W(32)) ms();
  wb_retire_queue dut (
    .clk(clk), .reset(reset), .ms(ms), .rf_grant(rf_grant),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
    .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .wb_ex(wb_ex), .ertn_flush(ertn_flush), .wb_pc(wb_pc),
    .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .id_raddr(id_raddr), .id_fwd_hit(id_fwd_hit), .id_fwd_data(id_fwd_data),
    .id_fwd_stall(id_fwd_stall), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_we(debug_wb_rf_we), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (rf_we | wb_ex | ertn_flush | csr_we) begin
      act = {wb_ex, ertn_flush, rf_we, csr_we, rf_we ? rf_waddr : 5'd0,
             rf_we ? rf_wdata : 32'd0, wb_ecode, wb_esubcode};
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_retire got=%h exp=none", act);
      end else begin
        expv = sbq.pop_front();
        if (act !== expv) begin
          errors++;
          $display("FAIL retire_event got=%h exp=%h", act, expv);
        end
      end
    end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic [4:0] a, input logic [31:0] d, input logic cre, input logic cwe,
                     input logic ex, input logic ertn, input logic [5:0] ec);
    ms.ms2ws_valid = 1'b1;
    ms.ms_pc = 32'h1000 + {27'd0, a};
    ms.ms_rf_zip = {cre, 1'b1, a, d};
    ms.ms_csr_zip = {cwe, 14'h5, 32'hffff_ffff, d};
    ms.ms_ex_zip = {ex, ertn, ec, ex ? 9'h3 : 9'h0};
  endtask
  task automatic idle();
    ms.ms2ws_valid = 1'b0;
  endtask
  task automatic expect_ev(input logic ex, input logic ertn, input logic we, input logic cwe,
                           input logic [4:0] a, input logic [31:0] d, input logic [5:0] ec,
                           input logic [8:0] es);
    sbq.push_back({ex, ertn, we, cwe, a, d, ec, es});
  endtask
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
  initial begin
    idle();
    ms.ms_pc = '0; ms.ms_rf_zip = '0; ms.ms_csr_zip = '0; ms.ms_ex_zip = '0;
    id_raddr = '0;
    csr_rvalue = 32'h1234;
    #2;
    chk("reset_rf_we", {31'd0, rf_we}, 32'd0);
    chk("reset_allowin", {31'd0, ms.ws_allowin}, 32'd0);
    chk("reset_wb_pc", wb_pc, 32'd0);
    step(); step();
    reset = 0;
    #1;
    chk("empty_allowin", {31'd0, ms.ws_allowin}, 32'd1);
    // in-order stream, one retire per cycle
    rf_grant = 1;
    chk("latency_pre", {31'd0, rf_we}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      put(5'(k), 32'(k * 'h11), 0, 0, 0, 0, 0);
      expect_ev(0, 0, 1, 0, 5'(k), 32'(k * 'h11), 0, 0);
      step();
      if (k == 1) chk("latency_first", {26'd0, rf_we, rf_waddr}, {26'd0, 1'b1, 5'd1});
    end
    idle(); step(); step();
    // fill without grant, then retire and accept in the same cycle
    rf_grant = 0;
    put(1, 32'h51, 0, 0, 0, 0, 0); expect_ev(0, 0, 1, 0, 1, 32'h51, 0, 0); step();
    put(2, 32'h52, 0, 0, 0, 0, 0); expect_ev(0, 0, 1, 0, 2, 32'h52, 0, 0); step();
    put(3, 32'h53, 0, 0, 0, 0, 0); expect_ev(0, 0, 1, 0, 3, 32'h53, 0, 0);
    @(negedge clk) chk("full_allowin", {31'd0, ms.ws_allowin}, 32'd0);
    step();
    rf_grant = 1;
    @(negedge clk) chk("full_retire_allowin", {31'd0, ms.ws_allowin}, 32'd1);
    step();
    idle(); rf_grant = 0;
    @(negedge clk) chk("count_held", {31'd0, ms.ws_allowin}, 32'd0);
    step();
    rf_grant = 1;
    step(); step(); step();
    // bypass picks the youngest writer
    rf_grant = 0;
    put(5, 32'hA, 0, 0, 0, 0, 0); expect_ev(0, 0, 1, 0, 5, 32'hA, 0, 0); step();
    put(5, 32'hB, 0, 0, 0, 0, 0); expect_ev(0, 0, 1, 0, 5, 32'hB, 0, 0); step();
    idle();
    id_raddr = {5'd9, 5'd5};
    @(negedge clk);
    chk("byp_hit", {30'd0, id_fwd_hit}, 32'd1);
    chk("byp_data", id_fwd_data[31:0], 32'hB);
    step();
    rf_grant = 1;
    step();
    @(negedge clk) chk("byp_after1", {id_fwd_hit[0], id_fwd_data[30:0]}, {1'b1, 31'hB});
    step();
    @(negedge clk) chk("byp_after2", {30'd0, id_fwd_hit}, 32'd0);
    rf_grant = 0;
    put(0, 32'h77, 0, 0, 0, 0, 0); expect_ev(0, 0, 1, 0, 0, 32'h77, 0, 0); step();
    idle();
    id_raddr = 10'd0;
    @(negedge clk) chk("byp_r0", {30'd0, id_fwd_hit}, 32'd0);
    step();
    rf_grant = 1;
    step(); step();
    // exception at head flushes the younger entry and drops the incoming one
    rf_grant = 0;
    put(2, 32'h22, 0, 0, 0, 0, 0); expect_ev(0, 0, 1, 0, 2, 32'h22, 0, 0); step();
    put(9, 32'h99, 0, 1, 1, 0, 6'hB); expect_ev(1, 0, 0, 0, 0, 0, 6'hB, 9'h3); step();
    rf_grant = 1;
    put(3, 32'h33, 0, 0, 0, 0, 0);
    id_raddr = {5'd9, 5'd3};
    @(negedge clk) chk("ex_excluded", {31'd0, id_fwd_hit[1]}, 32'd0);
    step();
    put(4, 32'h44, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("ex_young_hit", {30'd0, id_fwd_hit}, 32'd1);
    chk("ex_allowin", {31'd0, ms.ws_allowin}, 32'd1);
    chk("ex_csr_we", {31'd0, csr_we}, 32'd0);
    step();
    idle();
    @(negedge clk);
    chk("ex_flushed_hit", {30'd0, id_fwd_hit}, 32'd0);
    chk("ex_flushed_pc", wb_pc, 32'd0);
    step(); step();
    // ertn retires without a grant
    rf_grant = 0;
    put(10, 32'h1, 0, 0, 0, 1, 0); expect_ev(0, 1, 0, 0, 0, 0, 0, 0); step();
    idle(); step(); step();
    // CSR read: bypass stalls, retire writes the CSR read value
    put(7, 32'hdead, 1, 1, 0, 0, 0); expect_ev(0, 0, 1, 1, 7, 32'h1234, 0, 0); step();
    idle();
    id_raddr = {5'd0, 5'd7};
    @(negedge clk);
    chk("csr_stall", {30'd0, id_fwd_stall}, 32'd1);
    chk("csr_hit_data", {id_fwd_hit[0], id_fwd_data[30:0]}, {1'b1, 31'd0});
    chk("csr_head", {17'd0, csr_re, csr_num}, {17'd0, 1'b1, 14'h5});
    step();
    rf_grant = 1;
    @(negedge clk) chk("csr_wvalue", csr_wvalue, 32'hdead);
    step(); step();
    // reset with queued entries discards them
    rf_grant = 0;
    put(11, 32'h1, 0, 0, 0, 0, 0); step();
    put(12, 32'h2, 0, 0, 0, 0, 0); step();
    idle();
    id_raddr = {5'd0, 5'd11};
    @(negedge clk) chk("pre_reset_pc", wb_pc, 32'h100B);
    #1 reset = 1; rf_grant = 1;
    #1;
    chk("rst_outputs", {25'd0, rf_we, csr_we, wb_ex, ertn_flush, ms.ws_allowin, id_fwd_hit}, 32'd0);
    chk("rst_pc", wb_pc, 32'd0);
    step();
    reset = 0;
    step(); step(); step();
    chk("post_reset_hit", {30'd0, id_fwd_hit}, 32'd0);
    chk("sb_empty", sbq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
